fwd_hazard_unit: RTL and testbench

Parametrised forwarding and hazard controller for the pipelined RV32 core, the successor to the two-source combinational forwarding logic. It produces per-source EX-stage forward selects for any number of read ports, plus store-data forwarding. It detects load-use hazards and holds a registered scoreboard of destinations owned by in-flight multi-cycle operations such as mul/div or variable-latency loads, stalling ID until those operations complete. It sits beside the ID/EX, EX/MEM and MEM/WB pipeline registers and drives the stall/flush control of IF/ID.

---
 rtl/hazard_pkg.sv | 17 +
 rtl/reg_scoreboard.sv | 46 ++++
 rtl/fwd_hazard_unit.sv | 94 +++++++++
 tb/tb_fwd_hazard_unit.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared forwarding-select encodings and the priority helper used per read port.
package hazard_pkg;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF    = 2'b00;
  localparam fwd_sel_t FWD_MEMWB = 2'b01;
  localparam fwd_sel_t FWD_EXMEM = 2'b10;

  // EX/MEM is the younger producer, so it beats MEM/WB when both match.
  function automatic fwd_sel_t fwd_pick(input logic exmem_hit, input logic memwb_hit);
    if (exmem_hit)      return FWD_EXMEM;
    else if (memwb_hit) return FWD_MEMWB;
    else                return FWD_RF;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-destination scoreboard for in-flight multi-cycle ops, with a sticky
// flag for completions that target a register nobody owns.
module reg_scoreboard #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       issue,
  input  logic [REG_ADDR_W-1:0]      issue_rd,
  input  logic                       flush,
  input  logic                       done,
  input  logic [REG_ADDR_W-1:0]      done_rd,
  output logic [2**REG_ADDR_W-1:0]   pending,
  output logic                       done_err
);

  localparam int NUM_REGS = 2**REG_ADDR_W;
  localparam logic [NUM_REGS-1:0] ONE_HOT0 = {{(NUM_REGS-1){1'b0}}, 1'b1};

  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_vec;
  logic [NUM_REGS-1:0] pending_next;
  logic                err_hit;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue && !flush && (issue_rd != '0)) set_vec = ONE_HOT0 << issue_rd;
    if (done)                                clr_vec = ONE_HOT0 << done_rd;
    // Clear before set: a same-cycle issue to the completing rd keeps ownership.
    pending_next    = (pending & ~clr_vec) | set_vec;
    pending_next[0] = 1'b0;
    err_hit         = done && (done_rd != '0) && !pending[done_rd];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= '0;
      done_err <= 1'b0;
    end else begin
      pending <= pending_next;
      if (err_hit) done_err <= 1'b1;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX-stage operand forwarding, store-data forwarding and ID stall generation
// (load-use, scoreboard RAW, scoreboard WAW) with a saturating stall counter.
module fwd_hazard_unit
  import hazard_pkg::*;
#(
  parameter int NUM_SRC     = 2,
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs,
  input  logic [NUM_SRC-1:0]            id_rs_used,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] ex_rs,
  input  logic [REG_ADDR_W-1:0]         id_ex_rd,
  input  logic                          id_ex_mem_read,
  input  logic [REG_ADDR_W-1:0]         ex_mem_rd,
  input  logic [REG_ADDR_W-1:0]         mem_wb_rd,
  input  logic                          ex_mem_reg_write,
  input  logic                          mem_wb_reg_write,
  input  logic [REG_ADDR_W-1:0]         ex_mem_rs2,
  input  logic                          long_issue,
  input  logic [REG_ADDR_W-1:0]         long_issue_rd,
  input  logic                          flush,
  input  logic                          long_done,
  input  logic [REG_ADDR_W-1:0]         long_done_rd,
  input  logic                          id_long,
  input  logic [REG_ADDR_W-1:0]         id_rd,
  output logic [NUM_SRC*2-1:0]          forward_sel,
  output logic                          forward_mem,
  output logic                          stall,
  output logic                          done_err,
  output logic [STALL_CNT_W-1:0]        stall_cycles
);

  localparam int NUM_REGS = 2**REG_ADDR_W;
  localparam logic [STALL_CNT_W-1:0] CNT_MAX = '1;
  localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  logic [NUM_REGS-1:0] pending;
  logic [NUM_SRC-1:0]  lu_hit;
  logic [NUM_SRC-1:0]  sb_hit;
  logic                exmem_valid;
  logic                memwb_valid;
  logic                load_use;
  logic                sb_hazard;
  logic                waw_hazard;

  reg_scoreboard #(.REG_ADDR_W(REG_ADDR_W)) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .issue    (long_issue),
    .issue_rd (long_issue_rd),
    .flush    (flush),
    .done     (long_done),
    .done_rd  (long_done_rd),
    .pending  (pending),
    .done_err (done_err)
  );

  // x0 is never a real producer, so writes to it are not forwarding sources.
  assign exmem_valid = ex_mem_reg_write && (ex_mem_rd != '0);
  assign memwb_valid = mem_wb_reg_write && (mem_wb_rd != '0);

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    logic [REG_ADDR_W-1:0] ex_src;
    logic [REG_ADDR_W-1:0] id_src;
    assign ex_src = ex_rs[k*REG_ADDR_W +: REG_ADDR_W];
    assign id_src = id_rs[k*REG_ADDR_W +: REG_ADDR_W];

    assign forward_sel[k*2 +: 2] = fwd_pick(exmem_valid && (ex_mem_rd == ex_src),
                                            memwb_valid && (mem_wb_rd == ex_src));
    assign lu_hit[k] = id_rs_used[k] && (id_src == id_ex_rd);
    assign sb_hit[k] = id_rs_used[k] && pending[id_src];
  end

  assign forward_mem = memwb_valid && (mem_wb_rd == ex_mem_rs2);

  // Scoreboard checks use registered pending only; regfile write-then-read
  // ordering lets the consumer go the cycle after long_done.
  assign load_use   = id_ex_mem_read && (id_ex_rd != '0) && (|lu_hit);
  assign sb_hazard  = |sb_hit;
  assign waw_hazard = id_long && pending[id_rd];
  assign stall      = load_use || sb_hazard || waw_hazard;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != CNT_MAX)) begin
      stall_cycles <= stall_cycles + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed scenarios plus randomized traffic against a rule-level reference
// model of forwarding, hazards, the pending set and the stall counter.
module tb_fwd_hazard_unit;

  localparam int NS = 3;
  localparam int W  = 5;
  localparam int CW = 3;
  localparam int NR = 2**W;
  localparam int CNT_SAT = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NS*W-1:0] id_rs, ex_rs;
  logic [NS-1:0]   id_rs_used;
  logic [W-1:0]    id_ex_rd, ex_mem_rd, mem_wb_rd, ex_mem_rs2;
  logic [W-1:0]    long_issue_rd, long_done_rd, id_rd;
  logic            id_ex_mem_read, ex_mem_reg_write, mem_wb_reg_write;
  logic            long_issue, flush, long_done, id_long;
  logic [NS*2-1:0] forward_sel;
  logic            forward_mem, stall, done_err;
  logic [CW-1:0]   stall_cycles;

  fwd_hazard_unit #(.NUM_SRC(NS), .REG_ADDR_W(W), .STALL_CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rs_used(id_rs_used), .ex_rs(ex_rs),
    .id_ex_rd(id_ex_rd), .id_ex_mem_read(id_ex_mem_read), .ex_mem_rd(ex_mem_rd),
    .mem_wb_rd(mem_wb_rd), .ex_mem_reg_write(ex_mem_reg_write),
    .mem_wb_reg_write(mem_wb_reg_write), .ex_mem_rs2(ex_mem_rs2),
    .long_issue(long_issue), .long_issue_rd(long_issue_rd), .flush(flush),
    .long_done(long_done), .long_done_rd(long_done_rd), .id_long(id_long), .id_rd(id_rd),
    .forward_sel(forward_sel), .forward_mem(forward_mem), .stall(stall),
    .done_err(done_err), .stall_cycles(stall_cycles)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model state
  bit  m_pend[NR];
  bit  m_err;
  int  m_cnt;
  logic [31:0] exp_q[$];
  int  n_cmp = 0;
  int  n_mis = 0;
  logic last_stall;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_err = 1'b0;
    m_cnt = 0;
  endfunction

  function automatic void model_comb(output logic [NS*2-1:0] f, output logic fm, output logic st);
    bit lu, sb, waw;
    f = '0;
    lu = 0; sb = 0;
    for (int k = 0; k < NS; k++) begin
      int e, d;
      e = ex_rs[k*W +: W];
      d = id_rs[k*W +: W];
      if (ex_mem_reg_write && ex_mem_rd != 0 && ex_mem_rd == e)      f[k*2 +: 2] = 2'b10;
      else if (mem_wb_reg_write && mem_wb_rd != 0 && mem_wb_rd == e) f[k*2 +: 2] = 2'b01;
      if (id_rs_used[k] && id_ex_mem_read && id_ex_rd != 0 && d == id_ex_rd) lu = 1;
      if (id_rs_used[k] && m_pend[d]) sb = 1;
    end
    fm  = mem_wb_reg_write && mem_wb_rd != 0 && mem_wb_rd == ex_mem_rs2;
    waw = id_long && m_pend[id_rd];
    st  = lu || sb || waw;
  endfunction

  function automatic void model_seq(input logic st);
    if (long_done && long_done_rd != 0 && !m_pend[long_done_rd]) m_err = 1'b1;
    if (long_done) m_pend[long_done_rd] = 1'b0;
    if (long_issue && !flush && long_issue_rd != 0) m_pend[long_issue_rd] = 1'b1;
    if (st && m_cnt < CNT_SAT) m_cnt++;
  endfunction

  // driver tasks
  task automatic set_idle();
    id_rs = '0; ex_rs = '0; id_rs_used = '0;
    id_ex_rd = '0; ex_mem_rd = '0; mem_wb_rd = '0; ex_mem_rs2 = '0;
    long_issue_rd = '0; long_done_rd = '0; id_rd = '0;
    id_ex_mem_read = 0; ex_mem_reg_write = 0; mem_wb_reg_write = 0;
    long_issue = 0; flush = 0; long_done = 0; id_long = 0;
  endtask

  // Inputs are already applied (just after a negedge); ends at the next negedge.
  task automatic step();
    logic [NS*2-1:0] e_f;
    logic e_fm, e_st;
    logic [31:0] e_reg;
    #1;
    model_comb(e_f, e_fm, e_st);
    check("forward_sel", forward_sel, e_f);
    check("forward_mem", forward_mem, e_fm);
    check("stall", stall, e_st);
    last_stall = stall;
    @(posedge clk);
    model_seq(e_st);
    exp_q.push_back({m_err, 31'(m_cnt)});
    @(negedge clk);
    e_reg = exp_q.pop_front();
    check("done_err", done_err, e_reg[31]);
    check("stall_cycles", stall_cycles, e_reg[30:0]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    #2;
    model_reset();
    @(negedge clk);
    rst_n = 1;
    check("rst_done_err", done_err, 0);
    check("rst_stall_cycles", stall_cycles, 0);
  endtask

  task automatic randomize_inputs();
    for (int k = 0; k < NS; k++) begin
      id_rs[k*W +: W] = W'($urandom_range(0, 7));
      ex_rs[k*W +: W] = W'($urandom_range(0, 7));
    end
    id_rs_used       = NS'($urandom);
    id_ex_rd         = W'($urandom_range(0, 7));
    ex_mem_rd        = W'($urandom_range(0, 7));
    mem_wb_rd        = W'($urandom_range(0, 7));
    ex_mem_rs2       = W'($urandom_range(0, 7));
    id_ex_mem_read   = ($urandom_range(0, 3) == 0);
    ex_mem_reg_write = $urandom_range(0, 1);
    mem_wb_reg_write = $urandom_range(0, 1);
    long_issue       = ($urandom_range(0, 3) == 0);
    long_issue_rd    = W'($urandom_range(0, 7));
    flush            = ($urandom_range(0, 7) == 0);
    id_long          = ($urandom_range(0, 3) == 0);
    id_rd            = W'($urandom_range(0, 7));
    long_done        = 0;
    long_done_rd     = '0;
    if ($urandom_range(0, 2) == 0) begin
      for (int t = 0; t < 8; t++) begin
        int r;
        r = $urandom_range(1, 7);
        if (m_pend[r]) begin
          long_done = 1; long_done_rd = W'(r);
        end
      end
      if (!long_done && $urandom_range(0, 15) == 0) begin
        long_done = 1; long_done_rd = W'($urandom_range(0, 7));
      end
    end
  endtask

  initial begin
    set_idle();
    model_reset();
    last_stall = 0;
    #12;
    check("reset_done_err", done_err, 0);
    check("reset_stall_cycles", stall_cycles, 0);
    @(negedge clk);
    rst_n = 1;

    // forwarding priority
    ex_rs[0 +: W] = 5; ex_mem_rd = 5; mem_wb_rd = 5;
    ex_mem_reg_write = 1; mem_wb_reg_write = 1;
    step();
    check("fwd_exmem", forward_sel[1:0], 2'b10);
    ex_mem_reg_write = 0;
    step();
    check("fwd_memwb", forward_sel[1:0], 2'b01);
    ex_rs = '0; ex_mem_rd = 0; mem_wb_rd = 0; ex_mem_reg_write = 1;
    step();
    check("fwd_x0", forward_sel[1:0], 2'b00);
    mem_wb_rd = 6; ex_mem_rs2 = 6;
    step();
    check("fwd_store", forward_mem, 1);
    set_idle();

    // load-use: one stall, then MEM/WB forward
    id_ex_mem_read = 1; id_ex_rd = 7; id_rs[W +: W] = 7; id_rs_used = 3'b010;
    step();
    check("lu_stall", last_stall, 1);
    id_ex_mem_read = 0; id_ex_rd = 0; ex_mem_rd = 7; ex_mem_reg_write = 1;
    step();
    check("lu_release", last_stall, 0);
    set_idle();
    ex_rs[W +: W] = 7; mem_wb_rd = 7; mem_wb_reg_write = 1;
    step();
    check("lu_fwd", forward_sel[3:2], 2'b01);
    set_idle();
    id_ex_mem_read = 1; id_ex_rd = 7; id_rs[W +: W] = 7; id_rs_used = 3'b001;
    step();
    check("lu_unused", last_stall, 0);
    set_idle();

    // long op: issue x9, consumer stalls cycles 1..6
    do_reset();
    long_issue = 1; long_issue_rd = 9;
    step();
    long_issue = 0;
    id_rs[0 +: W] = 9; id_rs_used = 3'b001;
    for (int c = 1; c <= 7; c++) begin
      long_done = (c == 6); long_done_rd = 9;
      step();
      check($sformatf("long_stall_c%0d", c), last_stall, (c <= 6));
    end
    check("long_count", stall_cycles, 6);
    set_idle();

    // simultaneous issue/done, flush, rd=0
    do_reset();
    long_issue = 1; long_issue_rd = 9;
    step();
    long_done = 1; long_done_rd = 9;
    step();
    set_idle();
    id_rs[0 +: W] = 9; id_rs_used = 3'b001;
    step();
    check("same_rd_keeps", last_stall, 1);
    set_idle();
    long_done = 1; long_done_rd = 9;
    step();
    set_idle();
    long_issue = 1; long_issue_rd = 9; flush = 1;
    step();
    set_idle();
    id_rs[0 +: W] = 9; id_rs_used = 3'b001; id_long = 1; id_rd = 9;
    step();
    check("flush_no_set", last_stall, 0);
    set_idle();
    long_issue = 1; long_issue_rd = 0;
    step();
    set_idle();
    id_rs_used = 3'b111; id_long = 1; id_rd = 0;
    step();
    check("rd0_no_stall", last_stall, 0);
    set_idle();

    // done_err sticky, then saturation
    long_done = 1; long_done_rd = 12;
    step();
    set_idle();
    step();
    step();
    check("err_sticky", done_err, 1);
    long_issue = 1; long_issue_rd = 4;
    step();
    set_idle();
    id_long = 1; id_rd = 4;
    for (int c = 0; c < 10; c++) step();
    check("sat_count", stall_cycles, 3'd7);
    set_idle();

    // asynchronous reset mid-cycle with x4 still pending
    id_rs[0 +: W] = 4; id_rs_used = 3'b001;
    #1;
    check("pre_rst_stall", stall, 1);
    #3;
    rst_n = 0;
    #1;
    check("async_stall", stall, 0);
    check("async_done_err", done_err, 0);
    check("async_stall_cycles", stall_cycles, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    set_idle();
    long_done = 1; long_done_rd = 4;
    step();
    check("stale_done_err", done_err, 1);
    set_idle();

    // randomized traffic
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int c = 0; c < 120; c++) begin
        randomize_inputs();
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
